// File: rtl/program_sequencer_if.sv
// program_sequencer_if: processor tick/din and program memory bus of the instruction feeder.
interface program_sequencer_if #(parameter int ADDR_W = 6);
   logic [3:0]        tick;
   logic [8:0]        din;
   logic [ADDR_W-1:0] mem_addr;
   logic [8:0]        mem_data;
   modport master (input tick, mem_data, output din, mem_addr);
   modport slave (output tick, mem_data, input din, mem_addr);
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: feeds simple_proc instruction and immediate words in step with its tick phase.
module program_sequencer #(
   parameter int ADDR_W = 6,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   program_sequencer_if.master bus,
   input  logic              run,
   input  logic              step,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              issue,
   output logic [15:0]       retired
);
   localparam logic [1:0] HALTED = 2'd0, RUNNING = 2'd1, STEP = 2'd2;
   localparam logic [2:0] OP_HALT = 3'b110, OP_MOVI = 3'b111, OP_ADDI = 3'b010;
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1), TWO = ADDR_W'(2);
   logic [1:0]        state;
   logic              imm_pend, halt_lock;
   logic [ADDR_W-1:0] imm_addr;
   logic              issue_cyc, is_halt, is_imm, retire;
   assign issue_cyc = bus.tick == 4'b1000;
   assign is_halt = bus.mem_data[8:6] == OP_HALT;
   assign is_imm = bus.mem_data[8:6] == OP_MOVI || bus.mem_data[8:6] == OP_ADDI;
   assign issue = rst && issue_cyc && state != HALTED && !halt_lock;
   assign retire = issue && !is_halt;
   assign halted = state == HALTED;
   assign bus.mem_addr = imm_pend && !issue_cyc ? imm_addr : pc;
   // HALT words never reach the processor; it sees a NOP instead
   assign bus.din = !rst ? 9'h000 : issue_cyc ? (retire ? bus.mem_data : 9'h000) : imm_pend ? bus.mem_data : 9'h000;
   always_ff @(posedge clk)
      if (!rst) begin
         state <= HALTED;
         pc <= RESET_PC;
         imm_pend <= 1'b0;
         imm_addr <= RESET_PC;
         halt_lock <= 1'b0;
         retired <= 16'd0;
      end else begin
         halt_lock <= run && (halt_lock || (issue && is_halt));
         retired <= retired + {15'd0, retire};
         if (retire && is_imm) begin
            imm_pend <= 1'b1;
            imm_addr <= pc + ONE;
            pc <= pc + TWO;
         end else begin
            if (issue) pc <= pc + ONE;
            if (bus.tick == 4'b0100) imm_pend <= 1'b0;
         end
         if (issue && (is_halt || state == STEP)) state <= HALTED;
         else if (state == HALTED && run && !halt_lock) state <= RUNNING;
         else if (state == HALTED && step && !run) state <= STEP;
         else if (state == RUNNING && !run) state <= HALTED;
      end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed checks of program_sequencer against a tiny simple_proc register model.
`timescale 1ns/1ps
module tb_program_sequencer;
   logic clk = 1'b0, rst = 1'b0, run = 1'b0, step = 1'b0, rst_b = 1'b0, run_b = 1'b0;
   int checks = 0, failures = 0;
   logic [8:0] mem_a [64];
   logic [8:0] mem_b [8];
   logic [5:0] pc_a;
   logic [2:0] pc_b;
   logic halted_a, issue_a, halted_b, issue_b;
   logic [15:0] retired_a, retired_b;
   logic [8:0] ir;
   logic [15:0] r [8];
   logic [5:0] exp_pc [3];
   int n;
   program_sequencer_if #(.ADDR_W(6)) bus_a ();
   program_sequencer_if #(.ADDR_W(3)) bus_b ();
   program_sequencer #(.ADDR_W(6), .RESET_PC(6'd0)) dut (
      .clk(clk), .rst(rst), .bus(bus_a), .run(run), .step(step),
      .pc(pc_a), .halted(halted_a), .issue(issue_a), .retired(retired_a));
   program_sequencer #(.ADDR_W(3), .RESET_PC(3'd7)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b), .run(run_b), .step(1'b0),
      .pc(pc_b), .halted(halted_b), .issue(issue_b), .retired(retired_b));
   always #5 clk = ~clk;
   assign bus_a.mem_data = mem_a[bus_a.mem_addr];
   assign bus_b.mem_data = mem_b[bus_b.mem_addr];
   always @(posedge clk) begin
      bus_a.tick <= !rst ? 4'b0001 : {bus_a.tick[2:0], bus_a.tick[3]};
      bus_b.tick <= !rst_b ? 4'b0001 : {bus_b.tick[2:0], bus_b.tick[3]};
   end
   function automatic logic [15:0] sx(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction
   // processor model: IR loads on tick 1000, register write on tick 0010
   always @(posedge clk)
      if (!rst) begin
         ir <= 9'h000;
         for (int i = 0; i < 8; i++) r[i] <= 16'h0000;
      end else if (bus_a.tick == 4'b1000) ir <= bus_a.din;
      else if (bus_a.tick == 4'b0010)
         case (ir[8:6])
            3'b111: r[ir[5:3]] <= sx(bus_a.din);
            3'b010: r[ir[5:3]] <= r[ir[5:3]] + sx(bus_a.din);
            3'b001: r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
            default: ;
         endcase
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic clk1;
      @(posedge clk);
      #2;
   endtask
   task automatic t1000_a;
      for (int i = 0; i < 8 && bus_a.tick !== 4'b1000; i++) clk1;
      chk("tick1000_a", 32'(bus_a.tick), 32'h8);
   endtask
   task automatic t1000_b;
      for (int i = 0; i < 8 && bus_b.tick !== 4'b1000; i++) clk1;
      chk("tick1000_b", 32'(bus_b.tick), 32'h8);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < 64; i++) mem_a[i] = 9'h000;
      for (int i = 0; i < 8; i++) mem_b[i] = 9'h000;
      mem_a[0] = 9'h1C0;
      mem_a[1] = 9'h005;
      mem_a[2] = 9'h1C8;
      mem_a[3] = 9'h1FD;
      mem_a[4] = 9'h041;
      mem_a[5] = 9'h180;
      mem_b[7] = 9'h080;
      mem_b[0] = 9'h033;
      exp_pc[0] = 6'd2;
      exp_pc[1] = 6'd4;
      exp_pc[2] = 6'd5;
      rst = 1'b0;
      run = 1'b1;
      repeat (3) clk1;
      chk("rst_pc", 32'(pc_a), 0);
      chk("rst_halted", 32'(halted_a), 1);
      chk("rst_din", 32'(bus_a.din), 0);
      chk("rst_retired", 32'(retired_a), 0);
      chk("rst_issue", 32'(issue_a), 0);
      rst = 1'b1;
      clk1;
      clk1;
      chk("no_early_issue", 32'(issue_a), 0);
      clk1;
      chk("first_issue", 32'(issue_a), 1);
      chk("movi_r0_din", 32'(bus_a.din), 32'h1C0);
      clk1;
      chk("imm_t1", 32'(bus_a.din), 32'h005);
      clk1;
      chk("imm_t2", 32'(bus_a.din), 32'h005);
      chk("imm_addr", 32'(bus_a.mem_addr), 1);
      clk1;
      chk("imm_t4", 32'(bus_a.din), 32'h005);
      clk1;
      chk("movi_r1_din", 32'(bus_a.din), 32'h1C8);
      chk("movi_r1_pc", 32'(pc_a), 2);
      repeat (4) clk1;
      chk("add_din", 32'(bus_a.din), 32'h041);
      chk("add_pc", 32'(pc_a), 4);
      chk("add_retired_before", 32'(retired_a), 2);
      repeat (4) clk1;
      chk("halt_issue", 32'(issue_a), 1);
      chk("halt_din", 32'(bus_a.din), 0);
      clk1;
      chk("halt_pc", 32'(pc_a), 6);
      chk("halt_halted", 32'(halted_a), 1);
      chk("halt_retired", 32'(retired_a), 3);
      chk("r0_sum", 32'(r[0]), 32'h0002);
      chk("r1_sext", 32'(r[1]), 32'hFFFD);
      n = 0;
      repeat (20) begin
         clk1;
         if (issue_a) n++;
      end
      chk("lock_issues", n, 0);
      chk("lock_pc", 32'(pc_a), 6);
      run = 1'b0;
      clk1;
      run = 1'b1;
      clk1;
      t1000_a;
      chk("resume_issue", 32'(issue_a), 1);
      chk("resume_addr", 32'(bus_a.mem_addr), 6);
      clk1;
      chk("resume_pc", 32'(pc_a), 7);
      chk("resume_retired", 32'(retired_a), 4);
      run = 1'b0;
      clk1;
      chk("run_drop_halted", 32'(halted_a), 1);
      rst = 1'b0;
      clk1;
      clk1;
      rst = 1'b1;
      chk("step_rst_pc", 32'(pc_a), 0);
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         clk1;
         step = 1'b0;
         t1000_a;
         chk("step_issue", 32'(issue_a), 1);
         clk1;
         chk("step_pc", 32'(pc_a), 32'(exp_pc[k]));
         chk("step_retired", 32'(retired_a), k + 1);
         chk("step_halted", 32'(halted_a), 1);
         repeat (3) clk1;
         chk("step_idle_issue", 32'(issue_a), 0);
         chk("step_idle_din", 32'(bus_a.din), 0);
      end
      rst = 1'b0;
      clk1;
      rst = 1'b1;
      run = 1'b1;
      clk1;
      t1000_a;
      chk("mid_issue", 32'(bus_a.din), 32'h1C0);
      clk1;
      clk1;
      chk("mid_imm_din", 32'(bus_a.din), 32'h005);
      chk("mid_imm_pend", 32'(dut.imm_pend), 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_din_now", 32'(bus_a.din), 0);
      clk1;
      chk("mid_rst_din", 32'(bus_a.din), 0);
      chk("mid_rst_pend", 32'(dut.imm_pend), 0);
      chk("mid_rst_pc", 32'(pc_a), 0);
      run = 1'b0;
      rst = 1'b1;
      clk1;
      chk("mid_rel_pc", 32'(pc_a), 0);
      chk("mid_rel_halted", 32'(halted_a), 1);
      chk("wrap_rst_pc", 32'(pc_b), 7);
      rst_b = 1'b1;
      run_b = 1'b1;
      clk1;
      t1000_b;
      chk("wrap_issue", 32'(issue_b), 1);
      chk("wrap_addr7", 32'(bus_b.mem_addr), 7);
      chk("wrap_din", 32'(bus_b.din), 32'h080);
      clk1;
      chk("wrap_imm_din", 32'(bus_b.din), 32'h033);
      chk("wrap_imm_addr", 32'(bus_b.mem_addr), 0);
      chk("wrap_pc", 32'(pc_b), 1);
      clk1;
      chk("wrap_imm_t2", 32'(bus_b.din), 32'h033);
      clk1;
      clk1;
      chk("wrap_next_addr", 32'(bus_b.mem_addr), 1);
      chk("wrap_retired", 32'(retired_b), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction-feed controller for `simple_proc`. It fetches 9-bit words from a small asynchronous-read program memory and drives the processor's `din` port in phase with the processor's one-hot `tick`. Each instruction word is presented in the IR-load tick. For `movi`/`addi` the following immediate word is presented through the execute ticks. Whenever no instruction is issued it supplies NOP (9'h000), and it adds run/step/halt control and a retired-instruction counter for board bring-up and test benches.

## Interface
- `ADDR_W`, 6: program memory address width; PC wraps modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  single clock, shared with `simple_proc`.
- `rst`  in  1  synchronous, active-low reset.
- `tick`  in  4  one-hot phase from the processor's tick FSM (0001, 0010, 0100, 1000).
- `run`  in  1  level. While high, issue instructions continuously.
- `step`  in  1  pulse. While halted, issue exactly one instruction.
- `mem_addr`  out  ADDR_W  program memory read address (combinational).
- `mem_data`  in  9  program memory read data, valid in the same cycle as `mem_addr`.
- `din`  out  9  to `simple_proc.din` (combinational).
- `pc`  out  ADDR_W  address of the next instruction word.
- `halted`  out  1  high in HALTED state.
- `issue`  out  1  high during a tick-1000 cycle in which a real instruction is driven.
- `retired`  out  16  count of issued instructions; wraps at 16'hFFFF to 0.

## Operation
- States: HALTED, RUNNING, STEP. Reset enters HALTED.
- Issue cycle means any cycle with `tick`==1000, because the processor's IR loads `din` on that edge.
- An issue cycle is **active** when state is RUNNING or STEP and `halt_lock`==0.
- Active issue cycle:
  - `mem_addr`=`pc`, `issue`=1.
  - If `mem_data[8:6]`==110 (HALT): `din`=9'h000, and at the edge `pc`<=`pc`+1, state<=HALTED, `halt_lock`<=`run`. `retired` does not count it.
  - Else: `din`=`mem_data`, and `retired` increments at the edge.
    - If opcode is 111 (`movi`) or 010 (`addi`): `imm_pend`<=1, `imm_addr`<=`pc`+1, `pc`<=`pc`+2.
    - Otherwise: `pc`<=`pc`+1.
    - If state is STEP, state<=HALTED.
- Inactive issue cycle: `din`=9'h000, `issue`=0, nothing else changes.
- Ticks 0001/0010/0100:
  - `mem_addr`=`imm_addr` if `imm_pend`, else `pc`.
  - `din`=`mem_data` if `imm_pend`, else 9'h000.
  - `imm_pend` clears on the edge ending tick 0100.
- Transitions, evaluated every cycle at the edge:
  - HALTED to RUNNING when `run`=1 and `halt_lock`=0.
  - HALTED to STEP when `step`=1 and `run`=0.
  - RUNNING to HALTED when `run`=0. An already-fetched immediate still completes.
  - `step` is ignored outside HALTED.
  - `halt_lock` clears whenever `run`=0, so a HALT instruction stops the program until `run` is deasserted and reasserted.
- All PC additions are ADDR_W-bit and wrap:
  - an instruction at 2^ADDR_W−1 takes its immediate from address 0;
  - `pc`+2 wraps the same way.
- Opcodes 000, 100, 101 are passed through unchanged; the processor treats them as no-ops.

## Timing
- Reset values (cycle after `rst`=0 sampled):
  - `pc`=RESET_PC, state HALTED, `halted`=1, `imm_pend`=0, `halt_lock`=0, `retired`=0;
  - `issue`=0, `din`=9'h000.
- While `rst`=0, `din`=9'h000, `issue`=0, and no register updates except to reset values.
- Reset asserted mid-instruction (including while `imm_pend`=1) abandons the immediate. The top level must reset the processor in the same cycle.
- Latency:
  - from `run` rising, the first instruction issues at the first tick-1000 cycle at least one cycle later;
  - a `step` sampled in HALTED issues at the next tick-1000 cycle.
- `run` and `step` are both sampled on `clk`. A `step` pulse shorter than one cycle is not guaranteed.
- Throughput is one instruction per 4 cycles. Immediates cost no extra cycles.
- `pc`, `retired` and state all update on the edge that ends the issue cycle.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `run`=1. Require `pc`=0, `halted`=1, `din`=0, `retired`=0. Release it; the first issue occurs at the next tick 1000.
- **movi + add:** program [0]=111_000_000 (movi R0), [1]=9'h005, [2]=111_001_000 (movi R1), [3]=9'h1FD, [4]=001_000_001 (add R0,R1), [5]=110_000_000 (HALT). Run.
  - Require `din` = 9'h005 during ticks 0010/0100 of the first instruction.
  - Require R0 = 16'h0002 after the add.
  - Require `pc`=6, `halted`=1, `retired`=3.
- **Step mode:** same program with `run`=0. Each single-cycle `step` issues exactly one instruction: `pc` goes 0→2→4→5, `retired` increments by 1 each, and `din`=0 on all other tick-1000 cycles.
- **Halt lock:** after HALT, keep `run`=1 for 20 cycles and require no issue. Drop `run` for 1 cycle, reassert it, and require execution to resume at `pc`=6.
- **Wrap-around:** with ADDR_W=3, put `addi` at address 7 and its immediate at address 0. Require `din` = `mem[0]` during the execute ticks and `pc`=1 afterward.
- **Reset mid-immediate:** assert `rst`=0 during tick 0010 of a `movi`. Require `din`=0 the following cycle and `imm_pend`=0, with `pc`=RESET_PC after release.
